led_sequencer: RTL and testbench

- Parametrised microcode LED/PWM pattern sequencer; successor to the fixed 12-LED / 2x4-bit-PWM sequencer.
- Fetches instruction words from an external synchronous-read instruction memory and drives an LED vector plus N PWM duty-level channels.
- Adds: loop counter (LDC/DJNZ), HALT, start/restart control, illegal-opcode error flag.
- Sits between the microcode ROM and the LED driver / PWM generators.

---
 rtl/led_seq_pkg.sv | 35 +++
 rtl/led_sequencer_prescaler.sv | 27 ++
 rtl/led_sequencer.sv | 174 +++++++++++++++++
 tb/tb_led_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared constants for the microcode LED/PWM sequencer: opcodes, FSM state
// encoding and instruction-word field offsets derived from the parameters.
package led_seq_pkg;

  localparam logic [2:0] OP_WAIT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_LDC  = 3'd2;
  localparam logic [2:0] OP_DJNZ = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // Word layout, MSB to LSB: pwm fields, vec, opcode[2:0], arg
  function automatic int unsigned op_lsb(input int unsigned arg_w);
    return arg_w;
  endfunction

  function automatic int unsigned vec_lsb(input int unsigned arg_w);
    return arg_w + 3;
  endfunction

  function automatic int unsigned pwm_lsb(input int unsigned arg_w, input int unsigned vec_w);
    return arg_w + 3 + vec_w;
  endfunction

  function automatic int unsigned word_w(input int unsigned pwm_ch, input int unsigned pwm_w,
                                         input int unsigned vec_w, input int unsigned arg_w);
    return pwm_ch * pwm_w + vec_w + 3 + arg_w;
  endfunction

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Wait-tick prescaler: tick is high on every PRESCALE-th cycle after a clear.
module seq_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sequencer.sv
// Microcode LED/PWM pattern sequencer: fetches words from a synchronous-read
// instruction memory and drives a registered LED vector and PWM duty levels.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned VEC_W      = 12,
  parameter int unsigned PWM_CH     = 2,
  parameter int unsigned PWM_W      = 4,
  parameter int unsigned ARG_W      = 9,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned LOOP_W     = 8,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            imem_en,
  output logic [ADDR_W-1:0]               imem_addr,
  input  logic [PWM_CH*PWM_W+VEC_W+3+ARG_W-1:0] imem_data,
  output logic [VEC_W-1:0]                vec,
  output logic [PWM_CH*PWM_W-1:0]         pwm,
  output logic                            busy,
  output logic                            halted,
  output logic                            err
);

  localparam int unsigned PWM_TW  = PWM_CH * PWM_W;
  localparam int unsigned OP_LSB  = op_lsb(ARG_W);
  localparam int unsigned VEC_LSB = vec_lsb(ARG_W);
  localparam int unsigned PWM_LSB = pwm_lsb(ARG_W, VEC_W);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [ARG_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [PWM_TW-1:0] pwm_q, pwm_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              imem_en_q, imem_en_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

  logic [2:0]        word_op;
  logic [ARG_W-1:0]  word_arg;
  logic [VEC_W-1:0]  word_vec;
  logic [PWM_TW-1:0] word_pwm;
  logic [ADDR_W-1:0] pc_inc;
  logic              tick;

  assign word_op  = imem_data[OP_LSB +: 3];
  assign word_arg = imem_data[ARG_W-1:0];
  assign word_vec = imem_data[VEC_LSB +: VEC_W];
  assign word_pwm = imem_data[PWM_LSB +: PWM_TW];
  assign pc_inc   = pc_q + ADDR_W'(1);

  // Prescaler runs only while sitting in WAIT; every other state holds it cleared
  seq_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != ST_WAIT),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    vec_d      = vec_q;
    pwm_d      = pwm_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = ADDR_W'(START_ADDR);
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (word_op)
          OP_WAIT: begin
            vec_d      = word_vec;
            pwm_d      = word_pwm;
            wait_cnt_d = word_arg;
            if (word_arg == '0) pc_d = pc_inc;
            else                state_d = ST_WAIT;
          end
          OP_JUMP: pc_d = word_arg[ADDR_W-1:0];
          OP_LDC: begin
            loop_cnt_d = word_arg[LOOP_W-1:0];
            pc_d       = pc_inc;
          end
          OP_DJNZ: begin
            // A zero counter falls through without wrapping to all-ones
            if (loop_cnt_q == '0) begin
              pc_d = pc_inc;
            end else begin
              loop_cnt_d = loop_cnt_q - LOOP_W'(1);
              pc_d = (loop_cnt_q != LOOP_W'(1)) ? word_arg[ADDR_W-1:0] : pc_inc;
            end
          end
          OP_HALT: begin
            vec_d   = word_vec;
            pwm_d   = word_pwm;
            state_d = ST_HALT;
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_WAIT: begin
        if (tick) begin
          if (wait_cnt_q == ARG_W'(1)) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end else begin
            wait_cnt_d = wait_cnt_q - ARG_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_WAIT);
    halted_d    = (state_d == ST_HALT);
    imem_en_d   = (state_d == ST_FETCH);
    imem_addr_d = pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= ADDR_W'(START_ADDR);
      loop_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      vec_q       <= '0;
      pwm_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= ADDR_W'(START_ADDR);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      loop_cnt_q  <= loop_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      vec_q       <= vec_d;
      pwm_q       <= pwm_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  assign vec       = vec_q;
  assign pwm       = pwm_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a behavioural synchronous-read
// instruction memory and hand-computed expectations.
module tb_led_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [11:0] vec;
  logic [7:0]  pwm;
  logic        busy;
  logic        halted;
  logic        err;

  logic [31:0] mem [0:511];
  int checks;
  int errors;
  int fa[$];
  int fc[$];

  led_sequencer #(.PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .vec       (vec),
    .pwm       (pwm),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

  function automatic logic [31:0] w(input logic [3:0] p1, input logic [3:0] p0,
                                    input logic [11:0] v, input logic [2:0] op,
                                    input logic [8:0] a);
    return {p1, p0, v, op, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Record fetch addresses and their cycle indices until halted, bounded
  task automatic run_to_halt();
    int n;
    fa.delete();
    fc.delete();
    n = 0;
    while (!halted && n < 300) begin
      if (imem_en) begin
        fa.push_back(int'(imem_addr));
        fc.push_back(n);
      end
      step();
      n++;
    end
    chk("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  initial begin
    int n;
    int hits;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    imem_data = 32'h0;
    clear_mem();
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_vec", {20'b0, vec}, 32'h0);
    chk("rst_pwm", {24'b0, pwm}, 32'h0);
    chk("rst_flags", {27'b0, busy, halted, err, imem_en, 1'b0}, 32'h0);
    chk("rst_addr", {23'b0, imem_addr}, 32'h0);

    // WAIT 3 ticks at PRESCALE=4, then HALT clearing outputs
    mem[0] = w(4'h9, 4'h5, 12'hA5A, 3'd0, 9'd3);
    mem[1] = w(4'h0, 4'h0, 12'h000, 3'd4, 9'd0);
    pulse_start();
    chk("t1_fetch", {22'b0, busy, imem_en, imem_addr}, {22'b0, 1'b1, 1'b1, 9'd0});
    step();
    chk("t1_exec_vec_hold", {20'b0, vec}, 32'h0);
    step();
    chk("t1_vec", {20'b0, vec}, 32'hA5A);
    chk("t1_pwm", {24'b0, pwm}, 32'h95);
    n = 0;
    while (!imem_en && n < 100) begin
      n++;
      step();
    end
    chk("t1_wait_cycles", n, 32'd12);
    chk("t1_next_addr", {23'b0, imem_addr}, 32'd1);
    step();
    step();
    chk("t1_halt_out", {vec, pwm, 10'b0, busy, halted}, {12'h000, 8'h00, 10'b0, 1'b0, 1'b1});

    // Loop: WAIT at address 1 executes three times
    clear_mem();
    mem[0] = w(4'h0, 4'h0, 12'h000, 3'd2, 9'd3);
    mem[1] = w(4'h1, 4'h2, 12'h0F0, 3'd0, 9'd1);
    mem[2] = w(4'h0, 4'h0, 12'h000, 3'd3, 9'd1);
    mem[3] = w(4'h7, 4'h7, 12'h123, 3'd4, 9'd0);
    pulse_start();
    run_to_halt();
    hits = 0;
    foreach (fa[i]) if (fa[i] == 1) hits++;
    chk("t2_wait_execs", hits, 32'd3);
    chk("t2_fetches", fa.size(), 32'd8);
    chk("t2_halt_vec", {12'b0, vec, pwm}, {12'b0, 12'h123, 8'h77});

    // DJNZ with a zero counter falls through and leaves the counter at zero
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_mem();
    mem[0] = w(4'h0, 4'h0, 12'h000, 3'd3, 9'd5);
    mem[1] = w(4'h0, 4'h0, 12'h000, 3'd3, 9'd6);
    mem[2] = w(4'h0, 4'h0, 12'h0C3, 3'd4, 9'd0);
    mem[5] = w(4'h0, 4'h0, 12'hBAD, 3'd4, 9'd0);
    mem[6] = w(4'h0, 4'h0, 12'hBAD, 3'd4, 9'd0);
    pulse_start();
    run_to_halt();
    chk("t3_fetches", fa.size(), 32'd3);
    if (fa.size() == 3) chk("t3_third_addr", fa[2], 32'd2);
    chk("t3_vec", {20'b0, vec}, 32'h0C3);

    // Illegal opcode sets err and halts with outputs unchanged
    clear_mem();
    mem[0] = w(4'h2, 4'h1, 12'h3C3, 3'd0, 9'd0);
    mem[1] = w(4'h0, 4'h0, 12'h000, 3'd1, 9'd2);
    mem[2] = w(4'hF, 4'hF, 12'hFFF, 3'd6, 9'd0);
    pulse_start();
    run_to_halt();
    chk("t4_err", {30'b0, err, halted}, 32'h3);
    chk("t4_out_hold", {12'b0, vec, pwm}, {12'b0, 12'h3C3, 8'h21});
    pulse_start();
    chk("t4_restart", {20'b0, err, halted, busy, imem_en, imem_addr},
        {20'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0});
    run_to_halt();

    // start during WAIT is ignored; WAIT still lasts 12 cycles
    clear_mem();
    mem[0] = w(4'h3, 4'hC, 12'h555, 3'd0, 9'd3);
    mem[1] = w(4'h0, 4'h0, 12'h000, 3'd4, 9'd0);
    pulse_start();
    step();
    step();
    chk("t5_vec", {12'b0, vec, pwm}, {12'b0, 12'h555, 8'h3C});
    n = 0;
    while (!imem_en && n < 100) begin
      n++;
      if (n == 3) start = 1'b1;
      step();
      start = 1'b0;
    end
    chk("t5_wait_with_start", n, 32'd12);
    chk("t5_addr", {23'b0, imem_addr}, 32'd1);
    run_to_halt();

    // Reset in the middle of a WAIT
    pulse_start();
    step();
    step();
    for (int i = 0; i < 4; i++) step();
    chk("t5_in_wait", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    chk("t5_rst_out", {vec, pwm, 7'b0, busy, halted, err, imem_en, 1'b0},
        {12'h000, 8'h00, 12'h000});
    chk("t5_rst_addr", {23'b0, imem_addr}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t5_idle", {30'b0, busy, imem_en}, 32'd0);

    // JUMP to 0x1FF, WAIT 0 there, pc wraps to 0
    clear_mem();
    mem[0]     = w(4'h0, 4'h0, 12'h000, 3'd3, 9'd3);
    mem[1]     = w(4'h0, 4'h0, 12'h000, 3'd2, 9'd2);
    mem[2]     = w(4'h0, 4'h0, 12'h000, 3'd1, 9'h1FF);
    mem[9'h1FF] = w(4'h0, 4'h0, 12'h1E1, 3'd0, 9'd0);
    mem[3]     = w(4'h4, 4'hB, 12'h2D2, 3'd4, 9'd0);
    pulse_start();
    run_to_halt();
    chk("t6_fetches", fa.size(), 32'd6);
    if (fa.size() == 6) begin
      chk("t6_jump_addr", fa[3], 32'h1FF);
      chk("t6_wrap_addr", fa[4], 32'd0);
      chk("t6_wait0_cycles", fc[4] - fc[3], 32'd2);
      chk("t6_final_addr", fa[5], 32'd3);
    end
    chk("t6_halt_out", {12'b0, vec, pwm}, {12'b0, 12'h2D2, 8'h4B});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
